uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `async_transmitter` among NUM_REQ byte-stream requesters (loopback buffer, status reporter, hash-result reporter, etc.). Each requester presents bytes on a valid/ready handshake and marks the final byte of a packet. Once granted, a requester keeps the transmitter until that final byte is issued, so packets never interleave on `txd`. The arbiter drives `TxD_start`/`TxD_data` and paces itself from `TxD_busy`.

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Grant one cycle after request; 2 cycles/byte minimum; req_ready held low while txd_busy is high.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 txd_busy,
    output logic                 txd_start,
    output logic [7:0]           txd_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [15:0]          r_idle_cnt, w_idle_cnt_nxt;
    logic                 r_last_flag, w_last_flag_nxt;
    logic                 r_txd_start, w_txd_start_nxt;
    logic [7:0]           r_txd_data, w_txd_data_nxt;
    logic                 r_timeout, w_timeout_nxt;

    logic                 w_found;
    logic [IW-1:0]        w_pick;
    logic                 w_own_vld;
    logic                 w_accept;
    logic [15:0]          w_cnt_inc;

    // Round-robin scan starting just after the previous owner (r_owner doubles as last_owner).
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_owner) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(idx);
            end
        end
    end

    assign w_own_vld = req_valid[r_owner];
    assign w_accept  = (r_state == S_SEND) && w_own_vld && !txd_busy;
    assign w_cnt_inc = (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;

    always_comb begin
        req_ready = '0;
        if (r_state == S_SEND && !txd_busy) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_grant_nxt     = r_grant;
        w_idle_cnt_nxt  = r_idle_cnt;
        w_last_flag_nxt = r_last_flag;
        w_txd_start_nxt = 1'b0;
        w_txd_data_nxt  = r_txd_data;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_owner_nxt         = w_pick;
                    w_idle_cnt_nxt      = '0;
                    w_state_nxt         = S_SEND;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    w_txd_data_nxt  = req_data[8*int'(r_owner) +: 8];
                    w_txd_start_nxt = 1'b1;
                    w_last_flag_nxt = req_last[r_owner];
                    w_idle_cnt_nxt  = '0;
                    w_state_nxt     = S_HOLD;
                end else if (!w_own_vld) begin
                    // Owner stalled mid-packet: revoke once the idle budget is used up.
                    if ({16'd0, w_cnt_inc} >= 32'(IDLE_TIMEOUT)) begin
                        w_timeout_nxt  = 1'b1;
                        w_grant_nxt    = '0;
                        w_idle_cnt_nxt = '0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_idle_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_HOLD: begin
                // One-cycle gap lets TxD_busy rise before the next accept.
                if (r_last_flag) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner     <= IW'(NUM_REQ - 1);
            r_grant     <= '0;
            r_idle_cnt  <= '0;
            r_last_flag <= 1'b0;
            r_txd_start <= 1'b0;
            r_txd_data  <= 8'h00;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_grant     <= w_grant_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_last_flag <= w_last_flag_nxt;
            r_txd_start <= w_txd_start_nxt;
            r_txd_data  <= w_txd_data_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign txd_start   = r_txd_start;
    assign txd_data    = r_txd_data;
    assign grant       = r_grant;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a monitor
// matches every txd_start / timeout_err pulse against hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           txd_busy;
    logic           txd_start;
    logic [7:0]     txd_data;
    logic [N-1:0]   grant;
    logic           timeout_err;

    logic           force_busy;
    logic           stub_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        bit           is_to;
        logic [7:0]   data;
        logic [N-1:0] gnt;
    } exp_t;

    byte_t txq [N][$];
    exp_t  expq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    int to_gap = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign txd_busy = force_busy | stub_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .txd_busy    (txd_busy),
        .txd_start   (txd_start),
        .txd_data    (txd_data),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    // Requester driver: present queue heads, pop on a sampled handshake.
    initial begin : driver
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && txq[i].size() > 0) txq[i].delete(0);
                if (txq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = txq[i][0].data;
                    req_last[i]        = txq[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter stub: busy one cycle after start, for ten cycles.
    initial begin : stub
        int bcnt;
        bit seen;
        bcnt      = 0;
        seen      = 1'b0;
        stub_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bcnt > 0) bcnt--;
            if (seen) bcnt = 10;
            seen      = txd_start;
            stub_busy = (bcnt > 0);
        end
    end

    initial begin : monitor
        logic prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_start = 1'b0;
                continue;
            end
            checks++;
            if ((req_ready & {N{txd_busy}}) != '0) begin
                errors++;
                $display("FAIL ready_while_busy: req_ready=%b txd_busy=%b required req_ready=0", req_ready, txd_busy);
            end
            checks++;
            if (!$onehot0(req_ready) || (req_ready & ~grant) != '0) begin
                errors++;
                $display("FAIL ready_onehot: req_ready=%b grant=%b required one-hot-or-zero within grant", req_ready, grant);
            end
            checks++;
            if (prev_start && txd_start) begin
                errors++;
                $display("FAIL start_back_to_back: txd_start high two cycles in a row at cycle %0d", cyc);
            end
            prev_start = txd_start;
            if (txd_start || timeout_err) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: start=%b to=%b data=%h grant=%b with empty scoreboard",
                             txd_start, timeout_err, txd_data, grant);
                end else begin
                    e = expq.pop_front();
                    if (txd_start && timeout_err) begin
                        errors++;
                        $display("FAIL event_overlap: start and timeout_err both high");
                    end else if (e.is_to != timeout_err || (txd_start && e.data !== txd_data) || e.gnt !== grant) begin
                        errors++;
                        $display("FAIL event: got to=%b data=%h grant=%b required to=%b data=%h grant=%b",
                                 timeout_err, txd_data, grant, e.is_to, e.data, e.gnt);
                    end
                end
                if (txd_start) last_start_cyc = cyc;
                if (timeout_err) to_gap = cyc - last_start_cyc;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic l);
        txq[r].push_back({d, l});
    endtask

    task automatic exp_start(input logic [7:0] d, input logic [N-1:0] g);
        exp_t e;
        e.is_to = 1'b0;
        e.data  = d;
        e.gnt   = g;
        expq.push_back(e);
    endtask

    task automatic exp_timeout();
        exp_t e;
        e.is_to = 1'b1;
        e.data  = 8'h00;
        e.gnt   = '0;
        expq.push_back(e);
    endtask

    function automatic bit pending();
        bit p;
        p = (expq.size() != 0);
        for (int i = 0; i < N; i++) if (txq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 600) begin
            @(posedge clk);
            n++;
        end
        chk(name, {31'd0, pending()}, 32'd0);
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) txq[i].delete();
        expq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : test
        reset_n    = 1'b0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_txd_start", 32'(txd_start), 32'h0);
        chk("reset_txd_data", 32'(txd_data), 32'h0);
        chk("reset_timeout_err", 32'(timeout_err), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single packet from requester 2
        send(2, 8'h41, 1'b0); send(2, 8'h42, 1'b0); send(2, 8'h43, 1'b1);
        exp_start(8'h41, 4'b0100); exp_start(8'h42, 4'b0100); exp_start(8'h43, 4'b0100);
        wait_drain("single_drain");
        @(negedge clk);
        chk("single_grant_released", 32'(grant), 32'h0);

        // Contention: 0,1,3 together, then a second identical round
        do_reset();
        for (int r = 0; r < 2; r++) begin
            send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b1);
            send(1, 8'hB0, 1'b0); send(1, 8'hB1, 1'b1);
            send(3, 8'hD0, 1'b0); send(3, 8'hD1, 1'b1);
            exp_start(8'hA0, 4'b0001); exp_start(8'hA1, 4'b0001);
            exp_start(8'hB0, 4'b0010); exp_start(8'hB1, 4'b0010);
            exp_start(8'hD0, 4'b1000); exp_start(8'hD1, 4'b1000);
            wait_drain("contention_drain");
        end

        // Fairness: requester 1 joins while requester 0 streams two packets
        do_reset();
        send(0, 8'h60, 1'b0); send(0, 8'h61, 1'b1); send(0, 8'h62, 1'b0); send(0, 8'h63, 1'b1);
        exp_start(8'h60, 4'b0001); exp_start(8'h61, 4'b0001);
        exp_start(8'h70, 4'b0010); exp_start(8'h71, 4'b0010);
        exp_start(8'h62, 4'b0001); exp_start(8'h63, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        send(1, 8'h70, 1'b0); send(1, 8'h71, 1'b1);
        wait_drain("fairness_drain");

        // Timeout: requester 1 stalls after one byte, requester 2 waits
        do_reset();
        to_gap = -1;
        send(1, 8'h10, 1'b0);
        send(2, 8'h20, 1'b1);
        exp_start(8'h10, 4'b0010);
        exp_timeout();
        exp_start(8'h20, 4'b0100);
        wait_drain("timeout_drain");
        chk("timeout_latency", 32'(to_gap), 32'd9);

        // Busy gating
        do_reset();
        force_busy = 1'b1;
        send(3, 8'h5A, 1'b1);
        exp_start(8'h5A, 4'b1000);
        repeat (50) @(posedge clk);
        chk("busy_no_early_start", 32'(expq.size()), 32'd1);
        #1;
        force_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        chk("busy_release_start", 32'(txd_start), 32'h1);
        wait_drain("busy_drain");

        // Asynchronous reset mid-packet
        do_reset();
        send(2, 8'h31, 1'b0); send(2, 8'h32, 1'b0); send(2, 8'h33, 1'b1);
        exp_start(8'h31, 4'b0100);
        begin
            int n;
            n = 0;
            while (expq.size() != 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("areset_first_byte", 32'(expq.size()), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) txq[i].delete();
        #1;
        chk("areset_grant", 32'(grant), 32'h0);
        chk("areset_txd_data", 32'(txd_data), 32'h0);
        chk("areset_txd_start", 32'(txd_start), 32'h0);
        chk("areset_timeout_err", 32'(timeout_err), 32'h0);
        chk("areset_req_ready", 32'(req_ready), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(3, 8'h44, 1'b1);
        send(0, 8'h40, 1'b1);
        exp_start(8'h40, 4'b0001);
        exp_start(8'h44, 4'b1000);
        wait_drain("areset_after_drain");

        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
